// File: rtl/vgatext_console_writer.sv
// Terminal-style writer for the mono VGA text RAM: decodes a byte stream, tracks
// the cursor and clears the screen / new lines, yielding the RAM to the renderer.
module vgatext_console_writer #(
    parameter int                COLS   = 80,
    parameter int                ROWS   = 30,
    parameter int                ADDR_W = 13,
    parameter logic [ADDR_W-1:0] BASE   = '0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [7:0]        i_char,
    input  logic              i_char_valid,
    output logic              o_char_ready,
    input  logic              i_vgaram_busy,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [7:0]        o_ram_dat,
    output logic              o_ram_we,
    output logic [6:0]        o_cursor_col,
    output logic [4:0]        o_cursor_row,
    output logic              o_clearing,
    output logic [2:0]        o_state
);

    localparam int TOTAL = COLS * ROWS;
    localparam int PTR_W = $clog2(TOTAL);
    localparam logic [PTR_W-1:0]  PTR_ALL_LAST  = PTR_W'(TOTAL - 1);
    localparam logic [PTR_W-1:0]  PTR_LINE_LAST = PTR_W'(COLS - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE       = PTR_W'(1);
    localparam logic [6:0]        LAST_COL      = 7'(COLS - 1);
    localparam logic [4:0]        LAST_ROW      = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A        = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] ADDR_ONE      = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_CLR_ALL  = 3'd0,
        S_IDLE     = 3'd1,
        S_WRITE    = 3'd2,
        S_NEWLINE  = 3'd3,
        S_CLR_LINE = 3'd4
    } state_t;

    state_t            state, state_nx;
    logic              pend;      // a write is loaded in addr/dat and waits for a free RAM cycle
    logic              adv;       // the pending WRITE advances the cursor (printable, not BS)
    logic [PTR_W-1:0]  ptr;
    logic [ADDR_W-1:0] row_base;
    logic [6:0]        col;
    logic [4:0]        row;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        dat;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] nrow_base;
    logic              wr;
    logic              accept;
    logic              is_print;

    assign wr        = pend & ~i_vgaram_busy;
    assign accept    = i_char_valid & (state == S_IDLE);
    assign is_print  = (i_char >= 8'h20) && (i_char <= 8'h7E);
    assign cur_addr  = BASE + row_base + {{(ADDR_W-7){1'b0}}, col};
    assign nrow_base = (row == LAST_ROW) ? '0 : row_base + COLS_A;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= S_CLR_ALL;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_CLR_ALL:  if (wr && ptr == PTR_ALL_LAST) state_nx = S_IDLE;
            S_IDLE: begin
                if (accept) begin
                    if (is_print)                         state_nx = S_WRITE;
                    else if (i_char == 8'h0A)             state_nx = S_NEWLINE;
                    else if (i_char == 8'h08 && col != 0) state_nx = S_WRITE;
                    else if (i_char == 8'h0C)             state_nx = S_CLR_ALL;
                end
            end
            S_WRITE:    if (wr) state_nx = (adv && col == LAST_COL) ? S_NEWLINE : S_IDLE;
            S_NEWLINE:  state_nx = S_CLR_LINE;
            S_CLR_LINE: if (wr && ptr == PTR_LINE_LAST) state_nx = S_IDLE;
            default:    state_nx = S_CLR_ALL;
        endcase
    end

    always_comb begin
        o_char_ready = (state == S_IDLE);
        o_clearing   = (state == S_CLR_ALL) || (state == S_CLR_LINE);
        o_ram_we     = wr;
        o_state      = state;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pend     <= 1'b0;
            adv      <= 1'b0;
            ptr      <= '0;
            row_base <= '0;
            col      <= '0;
            row      <= '0;
            addr     <= BASE;
            dat      <= 8'h20;
        end else begin
            case (state)
                S_CLR_ALL: begin
                    if (!pend) begin
                        pend <= 1'b1;
                    end else if (wr) begin
                        if (ptr == PTR_ALL_LAST) begin
                            pend <= 1'b0;
                            ptr  <= '0;
                        end else begin
                            ptr  <= ptr + PTR_ONE;
                            addr <= addr + ADDR_ONE;
                        end
                    end
                end
                S_IDLE: begin
                    if (accept) begin
                        if (is_print) begin
                            addr <= cur_addr;
                            dat  <= i_char;
                            pend <= 1'b1;
                            adv  <= 1'b1;
                        end else if (i_char == 8'h0D) begin
                            col <= '0;
                        end else if (i_char == 8'h08 && col != 0) begin
                            col  <= col - 7'd1;
                            addr <= cur_addr - ADDR_ONE;
                            dat  <= 8'h20;
                            pend <= 1'b1;
                            adv  <= 1'b0;
                        end else if (i_char == 8'h0C) begin
                            col      <= '0;
                            row      <= '0;
                            row_base <= '0;
                            ptr      <= '0;
                            addr     <= BASE;
                            dat      <= 8'h20;
                            pend     <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (wr) begin
                        pend <= 1'b0;
                        if (adv && col != LAST_COL) col <= col + 7'd1;
                    end
                end
                S_NEWLINE: begin
                    col      <= '0;
                    row      <= (row == LAST_ROW) ? 5'd0 : row + 5'd1;
                    row_base <= nrow_base;
                    addr     <= BASE + nrow_base;
                    dat      <= 8'h20;
                    ptr      <= '0;
                    pend     <= 1'b1;
                end
                S_CLR_LINE: begin
                    if (wr) begin
                        if (ptr == PTR_LINE_LAST) begin
                            pend <= 1'b0;
                            ptr  <= '0;
                        end else begin
                            ptr  <= ptr + PTR_ONE;
                            addr <= addr + ADDR_ONE;
                        end
                    end
                end
                default: pend <= 1'b0;
            endcase
        end
    end

    assign o_ram_addr   = addr;
    assign o_ram_dat    = dat;
    assign o_cursor_col = col;
    assign o_cursor_row = row;

endmodule
